// File: rtl/key_action_ctrl.sv
// Frame-synchronous HID keycode to per-player action controller.
// Produces last-pressed-wins move levels and a cooldown-gated one-clock attack pulse.
module key_action_ctrl #(
  parameter int                          NUM_SLOTS       = 6,
  parameter int                          NUM_PLAYERS     = 2,
  parameter logic [24*NUM_PLAYERS-1:0]   KEYMAP          = 48'h82_79_80_1A_07_04,
  parameter int                          ATTACK_COOLDOWN = 30
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_tick,
  input  logic [8*NUM_SLOTS-1:0]   keycodes,
  output logic [NUM_PLAYERS-1:0]   move_l,
  output logic [NUM_PLAYERS-1:0]   move_r,
  output logic [NUM_PLAYERS-1:0]   attack,
  output logic [NUM_PLAYERS-1:0]   attack_ready
);

  localparam int CW = $clog2(ATTACK_COOLDOWN + 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} dirState_t;

  logic [NUM_PLAYERS-1:0] w_hitL, w_hitR, w_hitA;
  logic [NUM_PLAYERS-1:0] r_curL, r_curR, r_curA;

  // A zero map field disables that action, since empty report slots read as 8'h00.
  always_comb begin
    w_hitL = '0;
    w_hitR = '0;
    w_hitA = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if ((KEYMAP[24*p +: 8] != 8'h00) && (keycodes[8*s +: 8] == KEYMAP[24*p +: 8]))
          w_hitL[p] = 1'b1;
        if ((KEYMAP[24*p+8 +: 8] != 8'h00) && (keycodes[8*s +: 8] == KEYMAP[24*p+8 +: 8]))
          w_hitR[p] = 1'b1;
        if ((KEYMAP[24*p+16 +: 8] != 8'h00) && (keycodes[8*s +: 8] == KEYMAP[24*p+16 +: 8]))
          w_hitA[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_curL <= '0;
      r_curR <= '0;
      r_curA <= '0;
    end else if (frame_tick) begin
      r_curL <= w_hitL;
      r_curR <= w_hitR;
      r_curA <= w_hitA;
    end
  end

  genvar p;
  generate
    for (p = 0; p < NUM_PLAYERS; p++) begin : gPlayer
      dirState_t      r_state;
      dirState_t      w_stateNext;
      logic           r_moveL;
      logic           r_moveR;
      logic           r_attack;
      logic [CW-1:0]  r_cnt;
      logic           w_newL;
      logic           w_newR;
      logic           w_newA;

      assign w_newL = w_hitL[p] & ~r_curL[p];
      assign w_newR = w_hitR[p] & ~r_curR[p];
      assign w_newA = w_hitA[p] & ~r_curA[p];

      // Fresh presses win; on release fall back to the other key if it is still held.
      always_comb begin
        w_stateNext = r_state;
        if (frame_tick) begin
          if (w_newL && !w_newR)
            w_stateNext = LEFT;
          else if (w_newR && !w_newL)
            w_stateNext = RIGHT;
          else if (w_newL && w_newR)
            w_stateNext = IDLE;
          else if ((r_state == LEFT) && !w_hitL[p])
            w_stateNext = w_hitR[p] ? RIGHT : IDLE;
          else if ((r_state == RIGHT) && !w_hitR[p])
            w_stateNext = w_hitL[p] ? LEFT : IDLE;
        end
      end

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          r_state <= IDLE;
          r_moveL <= 1'b0;
          r_moveR <= 1'b0;
        end else begin
          r_state <= w_stateNext;
          r_moveL <= (w_stateNext == LEFT);
          r_moveR <= (w_stateNext == RIGHT);
        end
      end

      // Counter is tested before it decrements, so a press on the expiring frame is dropped.
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          r_cnt    <= '0;
          r_attack <= 1'b0;
        end else begin
          r_attack <= 1'b0;
          if (frame_tick) begin
            if (w_newA && (r_cnt == '0)) begin
              r_attack <= 1'b1;
              r_cnt    <= CW'(ATTACK_COOLDOWN);
            end else if (r_cnt != '0) begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
      end

      assign move_l[p]       = r_moveL;
      assign move_r[p]       = r_moveR;
      assign attack[p]       = r_attack;
      assign attack_ready[p] = (r_cnt == '0);
    end
  endgenerate

endmodule

// File: tb/tb_key_action_ctrl.sv
// Directed self-checking bench for key_action_ctrl with a short cooldown,
// plus a second instance whose player-0 left key is mapped to the disabled code 8'h00.
module tb_key_action_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic        frame_tick;
  logic [47:0] keycodes;
  logic [1:0]  move_l, move_r, attack, attack_ready;
  logic [1:0]  zMoveL, zMoveR, zAttack, zReady;

  int testCount = 0;
  int failCount = 0;
  int pulses;

  key_action_ctrl #(
    .NUM_SLOTS(6), .NUM_PLAYERS(2),
    .KEYMAP(48'h82_79_80_1A_07_04), .ATTACK_COOLDOWN(3)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycodes(keycodes),
    .move_l(move_l), .move_r(move_r), .attack(attack), .attack_ready(attack_ready)
  );

  key_action_ctrl #(
    .NUM_SLOTS(6), .NUM_PLAYERS(2),
    .KEYMAP(48'h82_79_80_1A_07_00), .ATTACK_COOLDOWN(3)
  ) dutZero (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycodes(keycodes),
    .move_l(zMoveL), .move_r(zMoveR), .attack(zAttack), .attack_ready(zReady)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One frame: present the report with frame_tick for one clock, return at the next negedge.
  task automatic applyStimulus(input logic [47:0] k);
    @(negedge Clk);
    keycodes   = k;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset_n    = 1'b0;
    frame_tick = 1'b0;
    keycodes   = '0;
    repeat (2) @(negedge Clk);
    checkOutput("rstMoveL", 32'(move_l), 32'h0);
    checkOutput("rstMoveR", 32'(move_r), 32'h0);
    checkOutput("rstAttack", 32'(attack), 32'h0);
    checkOutput("rstReady", 32'(attack_ready), 32'h3);
    Reset_n = 1'b1;

    applyStimulus(48'h00_00_00_00_00_04);
    checkOutput("f1MoveL", 32'(move_l), 32'h1);
    applyStimulus(48'h00_00_00_00_07_04);
    checkOutput("f2MoveR", 32'(move_r), 32'h1);
    checkOutput("f2MoveL", 32'(move_l), 32'h0);
    applyStimulus(48'h00_00_00_00_00_04);
    checkOutput("f3MoveL", 32'(move_l), 32'h1);
    checkOutput("f3MoveR", 32'(move_r), 32'h0);
    applyStimulus(48'h0);
    checkOutput("f4MoveL", 32'(move_l), 32'h0);
    checkOutput("f4MoveR", 32'(move_r), 32'h0);

    applyStimulus(48'h00_00_00_00_79_80);
    checkOutput("simulL", 32'(move_l), 32'h0);
    checkOutput("simulR", 32'(move_r), 32'h0);
    applyStimulus(48'h00_00_00_00_79_80);
    checkOutput("simulHeldL", 32'(move_l), 32'h0);
    checkOutput("simulHeldR", 32'(move_r), 32'h0);
    applyStimulus(48'h0);

    applyStimulus(48'h1A);
    checkOutput("atkPulse", 32'(attack), 32'h1);
    checkOutput("atkReady", 32'(attack_ready), 32'h2);
    @(negedge Clk);
    checkOutput("atkOneClk", 32'(attack), 32'h0);
    applyStimulus(48'h1A);
    checkOutput("atkBlock1", 32'(attack), 32'h0);
    applyStimulus(48'h0);
    checkOutput("atkNotReady", 32'(attack_ready), 32'h2);
    applyStimulus(48'h1A);
    checkOutput("atkBlockAtZero", 32'(attack), 32'h0);
    checkOutput("atkReadyAgain", 32'(attack_ready), 32'h3);
    applyStimulus(48'h0);
    applyStimulus(48'h1A);
    checkOutput("atkRefire", 32'(attack), 32'h1);

    repeat (4) applyStimulus(48'h0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(48'h1A);
      if (attack[0]) pulses++;
    end
    checkOutput("holdPulses", 32'(pulses), 32'h1);
    applyStimulus(48'h0);

    applyStimulus(48'h00_00_82_1A_07_80);
    checkOutput("multiMoveR", 32'(move_r), 32'h1);
    checkOutput("multiMoveL", 32'(move_l), 32'h2);
    checkOutput("multiAttack", 32'(attack), 32'h3);

    #1 Reset_n = 1'b0;
    #1;
    checkOutput("midRstAttack", 32'(attack), 32'h0);
    checkOutput("midRstMoveL", 32'(move_l), 32'h0);
    checkOutput("midRstMoveR", 32'(move_r), 32'h0);
    checkOutput("midRstReady", 32'(attack_ready), 32'h3);
    @(negedge Clk);
    Reset_n  = 1'b1;
    keycodes = 48'h04;
    repeat (3) @(negedge Clk);
    checkOutput("noTickMoveL", 32'(move_l), 32'h0);

    applyStimulus(48'h0);
    checkOutput("zeroCodeIdle", 32'(zMoveL), 32'h0);
    applyStimulus(48'h07);
    checkOutput("zeroCodeRight", 32'(zMoveR), 32'h1);
    applyStimulus(48'h0);
    checkOutput("zeroCodeRelease", 32'(zMoveL), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/key_action_ctrl.md
Name: key_action_ctrl

Overview:
- Frame-synchronous keyboard-to-action controller for N players.
- Samples the 6-slot USB HID keycode report once per frame tick and matches it against a per-player key map.
- Produces registered move_l/move_r levels with last-pressed-wins arbitration, plus a one-clock attack pulse gated by a per-player cooldown counter.
- Sits between the USB keycode register and the character state machines.

Parameters:
- NUM_SLOTS, 6, number of 8-bit keycode slots in the report.
- NUM_PLAYERS, 2, number of independent players.
- KEYMAP, 48'h82_79_80_1A_07_04, packed 24 bits per player p: [24p+7:24p] left, [24p+15:24p+8] right, [24p+23:24p+16] attack.
- ATTACK_COOLDOWN, 30, frame ticks during which a new attack is blocked after an attack fires (>=1).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-Clk pulse per video frame; all state advances only on this pulse.
- keycodes  in  8*NUM_SLOTS  HID report, slot i at [8i+7:8i].
- move_l  out  NUM_PLAYERS  per-player move-left level.
- move_r  out  NUM_PLAYERS  per-player move-right level.
- attack  out  NUM_PLAYERS  per-player one-Clk attack pulse.
- attack_ready  out  NUM_PLAYERS  per-player flag: cooldown counter == 0.

Behaviour:
- Reset (async, Reset_n=0):
  - move_l, move_r, attack = 0; attack_ready = all 1.
  - All held-key registers = 0; direction FSMs = IDLE; cooldown counters = 0.
  - Reset takes effect immediately mid-cooldown or mid-pulse.
- Hit detect (combinational):
  - hit_X[p] = 1 when any slot equals player p's map code for action X.
  - Code 8'h00 never matches, even if a map field is 0; that action is disabled.
  - Duplicate codes across slots are harmless.
  - Two players mapped to the same code both see the hit.
- Sampling:
  - On a Clk edge with frame_tick=1: prev_X <= cur_X, then cur_X <= hit_X.
  - All outputs are registered and update on that same edge, so they are valid one Clk after the frame_tick cycle.
  - With frame_tick=0, everything holds except attack, which clears to 0.
- Press edge: new_X = hit_X & ~cur_X, evaluated at the frame_tick edge.
- Direction FSM, per player; states IDLE, LEFT, RIGHT; evaluated only on frame_tick:
  - new_l & ~new_r -> LEFT.
  - new_r & ~new_l -> RIGHT.
  - new_l & new_r (same frame) -> IDLE.
  - Otherwise, if the current direction's key is released: go to the other direction if its key is still held, else IDLE.
  - Otherwise stay.
  - Outputs: move_l = (state==LEFT), move_r = (state==RIGHT); never both 1.
- Attack / cooldown, per player:
  - Counter width clog2(ATTACK_COOLDOWN+1).
  - On frame_tick with new_a=1 and counter==0: attack=1 for exactly one Clk; counter <= ATTACK_COOLDOWN.
  - Else, on frame_tick with counter != 0: counter decrements by 1, saturating at 0.
  - A press during cooldown is dropped, not queued.
  - Holding the key never re-fires; release and re-press are required.
  - A press on the same frame the counter reaches 0 is still blocked. The counter is checked before the decrement.
  - attack_ready = (counter==0).
- Players are fully independent; no cross-player interaction.

Test Plan:
- Reset: assert Reset_n=0 mid-cooldown -> immediately move_l=move_r=attack=0, attack_ready=2'b11; hold keycodes=48'h04 with no frame_tick -> no output change.
- P1 move and priority: frame1 slot0=8'h04 -> move_l[0]=1 one Clk after the tick. Frame2 adds slot1=8'h07 -> move_r[0]=1, move_l[0]=0. Frame3 removes 8'h07 -> move_l[0]=1. Frame4 all zero -> both 0.
- Simultaneous press: frame with 8'h80 and 8'h79 both newly present -> player 1 stays IDLE (move_l[1]=move_r[1]=0); keeping both held the next frame -> still IDLE.
- Attack cooldown, ATTACK_COOLDOWN=3: press 8'h1A -> attack[0] high exactly one Clk, attack_ready[0]=0. Release then re-press at ticks +1 and +2 -> no pulse. After 3 ticks attack_ready[0]=1. A fresh press then -> pulse.
- Hold attack: keep 8'h1A held for 10 frames -> exactly one pulse.
- Multi-player / zero code: keycodes=48'h00_00_82_1A_07_80 -> move_r[0]=1, move_l[1]=1, attack=2'b11 in the same Clk. Then override KEYMAP left field = 8'h00 with keycodes all zero -> move_l stays 0.
